// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: ALU control codes and the mul/div sequencer state type.
package mips_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_MULT = 4'b0011;
  localparam logic [3:0] ALU_DIV  = 4'b0100;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } md_state_e;

  function automatic logic is_muldiv(input logic [3:0] ctl);
    return (ctl == ALU_MULT) || (ctl == ALU_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned radix-2 shift-add multiply or restoring divide.
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             op_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] lo_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] lo_o
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  always_comb begin
    sum     = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shifted = {acc_i, lo_i[WIDTH-1]};
    // Top bit of the widened difference is the borrow: set means the trial went negative.
    trial   = shifted - {1'b0, opnd_i};
    acc_o   = '0;
    lo_o    = '0;
    if (op_div_i) begin
      if (!trial[WIDTH]) begin
        acc_o = trial[WIDTH-1:0];
        lo_o  = {lo_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = shifted[WIDTH-1:0];
        lo_o  = {lo_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = sum[WIDTH:1];
      lo_o  = {sum[0], lo_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle signed mult/div controller: magnitude iteration, sign fix-up, HI/LO commit.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       control,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_e          state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   acc_q, work_q, opnd_q, hi_q, lo_q;
  logic               sign_a_q, sign_b_q, div_q, dz_q;
  logic               busy_q, done_q, div_zero_q;
  logic [WIDTH-1:0]   acc_d, work_d, fix_hi_d, fix_lo_d;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [2*WIDTH-1:0] prod;
  logic               valid_op, is_div;

  assign valid_op = is_muldiv(control);
  assign is_div   = (control == ALU_DIV);
  assign abs_a    = a[WIDTH-1] ? -a : a;
  assign abs_b    = b[WIDTH-1] ? -b : b;

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign stall    = busy_q | (start & valid_op & (state_q == IDLE));

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_div_i (div_q),
    .acc_i    (acc_q),
    .lo_i     (work_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d),
    .lo_o     (work_d)
  );

  // work_q holds the dividend magnitude untouched on divide-by-zero, so it rebuilds the original a.
  always_comb begin
    prod     = {acc_q, work_q};
    fix_hi_d = '0;
    fix_lo_d = '0;
    if (dz_q) begin
      fix_hi_d = sign_a_q ? -work_q : work_q;
      fix_lo_d = '1;
    end else if (div_q) begin
      fix_lo_d = (sign_a_q ^ sign_b_q) ? -work_q : work_q;
      fix_hi_d = sign_a_q ? -acc_q : acc_q;
    end else begin
      if (sign_a_q ^ sign_b_q) prod = -prod;
      {fix_hi_d, fix_lo_d} = prod;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      acc_q      <= '0;
      work_q     <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      sign_a_q   <= 1'b0;
      sign_b_q   <= 1'b0;
      div_q      <= 1'b0;
      dz_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && valid_op && !flush) begin
            div_q    <= is_div;
            sign_a_q <= a[WIDTH-1];
            sign_b_q <= b[WIDTH-1];
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            work_q   <= is_div ? abs_a : abs_b;
            opnd_q   <= is_div ? abs_b : abs_a;
            dz_q     <= is_div && (b == '0);
            state_q  <= (is_div && (b == '0)) ? FIX : CALC;
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            acc_q  <= acc_d;
            work_q <= work_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          if (flush) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end else begin
            hi_q       <= fix_hi_d;
            lo_q       <= fix_lo_d;
            done_q     <= 1'b1;
            div_zero_q <= dz_q;
            state_q    <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed-vector bench for muldiv_sequencer with hand-computed HI/LO results and latencies.
module tb_muldiv_sequencer;
  import mips_pkg::*;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst, start, flush;
  logic [3:0]   control;
  logic [W-1:0] a, b;
  logic         busy, stall, done, div_zero;
  logic [W-1:0] hi, lo;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  muldiv_sequencer #(.WIDTH(W), .CNT_W(6)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .control  (control),
    .a        (a),
    .b        (b),
    .flush    (flush),
    .busy     (busy),
    .stall    (stall),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string name, input logic [3:0] ctl,
                        input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic edz, input int elat);
    int   n;
    logic stall_drop;
    @(negedge clk);
    start = 1'b1; control = ctl; a = av; b = bv;
    #1 check({name, "_stall_req"}, 64'(stall), 64'(1));
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    stall_drop = 1'b0;
    while (!done && n < 100) begin
      if (!stall) stall_drop = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(elat));
    check({name, "_stall_hold"}, 64'(stall_drop), 64'(0));
    check({name, "_hi"}, 64'(hi), 64'(ehi));
    check({name, "_lo"}, 64'(lo), 64'(elo));
    check({name, "_divzero"}, 64'(div_zero), 64'(edz));
    @(posedge clk); #1;
    check({name, "_done_pulse"}, 64'(done), 64'(0));
    check({name, "_idle"}, 64'(busy), 64'(0));
  endtask

  initial begin : main
    int   n;
    logic seen;
    rst = 1'b1; start = 1'b0; flush = 1'b0; control = 4'b0000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hi", 64'(hi), 64'(0));
    check("rst_lo", 64'(lo), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_done", 64'(done), 64'(0));
    check("rst_dz", 64'(div_zero), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    @(negedge clk); rst = 1'b0;

    run_op("mult_7_m3",   ALU_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 34);
    run_op("mult_m1_m1",  ALU_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,        32'h1,        1'b0, 34);
    run_op("mult_2p16",   ALU_MULT, 32'h00010000, 32'h00010000, 32'h1,        32'h0,        1'b0, 34);
    run_op("mult_m5_0",   ALU_MULT, 32'hFFFFFFFB, 32'h0,        32'h0,        32'h0,        1'b0, 34);
    run_op("div_m17_5",   ALU_DIV,  32'hFFFFFFEF, 32'd5,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 34);
    run_op("div_by_zero", ALU_DIV,  32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 1'b1, 2);
    run_op("div_ovf",     ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 34);
    run_op("div_7_m2",    ALU_DIV,  32'd7,        32'hFFFFFFFE, 32'h1,        32'hFFFFFFFD, 1'b0, 34);

    // Invalid control code: not accepted, no stall, HI/LO untouched.
    @(negedge clk);
    start = 1'b1; control = ALU_ADD; a = 32'd5; b = 32'd6;
    #1 check("bad_ctl_stall", 64'(stall), 64'(0));
    @(posedge clk); #1;
    check("bad_ctl_busy", 64'(busy), 64'(0));
    check("bad_ctl_hi", 64'(hi), 64'(1));
    start = 1'b0;

    // Flush in IDLE suppresses a simultaneous start.
    @(negedge clk);
    start = 1'b1; control = ALU_MULT; a = 32'd3; b = 32'd4; flush = 1'b1;
    @(posedge clk); #1;
    check("idle_flush_busy", 64'(busy), 64'(0));
    start = 1'b0; flush = 1'b0;

    // Flush at cycle 10 of a mult aborts it without a done.
    @(negedge clk);
    start = 1'b1; control = ALU_MULT; a = 32'd3; b = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 check("flush_busy_before", 64'(busy), 64'(1));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_idle", 64'(busy), 64'(0));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("flush_no_done", 64'(seen), 64'(0));
    check("flush_hi_kept", 64'(hi), 64'(1));
    check("flush_lo_kept", 64'(lo), 64'(32'hFFFFFFFD));

    // Asynchronous reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; control = ALU_DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_hi", 64'(hi), 64'(0));
    check("arst_lo", 64'(lo), 64'(0));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_stall", 64'(stall), 64'(0));
    @(negedge clk); rst = 1'b0;

    run_op("div_1000_7", ALU_DIV, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 34);

    // start held high through a whole operation: re-accepted only after done.
    @(negedge clk);
    start = 1'b1; control = ALU_MULT; a = 32'd2; b = 32'd3;
    @(posedge clk); #1;
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_first_lat", 64'(n), 64'(34));
    check("held_first_lo", 64'(lo), 64'(6));
    @(posedge clk); #1;
    check("held_idle_busy", 64'(busy), 64'(0));
    check("held_idle_stall", 64'(stall), 64'(1));
    @(posedge clk); #1;
    check("held_reaccept", 64'(busy), 64'(1));
    start = 1'b0;
    n = 1;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_second_lat", 64'(n), 64'(34));
    check("held_second_lo", 64'(lo), 64'(6));

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Multi-cycle controller for the shared iterative multiply/divide unit of the MIPS datapath.
- Accepts an operation when the ALU control code is 4'b0011 (mult) or 4'b0100 (div).
- Runs a radix-2 shift-add multiply or restoring divide over WIDTH cycles, stalls the pipeline meanwhile, then writes the HI/LO registers.
- Operations are signed (MIPS mult/div semantics).

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE.
- control  in  4  ALU control code; 4'b0011 = mult, 4'b0100 = div, anything else is ignored.
- a  in  WIDTH  rs operand (multiplicand / dividend).
- b  in  WIDTH  rt operand (multiplier / divisor).
- flush  in  1  pipeline flush; aborts the operation in progress.
- busy  out  1  high in CALC, FIX and DONE.
- stall  out  1  busy OR (start AND valid op AND state==IDLE); combinational.
- done  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- div_zero  out  1  high together with done when a div had b==0.
- hi  out  WIDTH  HI register (product upper half / remainder).
- lo  out  WIDTH  LO register (product lower half / quotient).

Behaviour:
- Reset (async): state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0, internal accumulators=0.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - On start with a valid op: latch |a|, |b|, sign_a, sign_b, op; clear the accumulator; counter=0.
  - Next state is CALC, except div with b==0, which goes directly to FIX.
  - start with an invalid control code: no state change, stall stays 0.
- CALC: one iteration per cycle; counter increments; after WIDTH iterations (counter==WIDTH-1 on the last one) go to FIX.
  - mult: 2*WIDTH-bit product register {acc, multiplier}. If the LSB is 1, add the multiplicand to the upper half (WIDTH+1-bit add to keep the carry), then shift right 1.
  - div: {rem, quo} shift left 1. Compute trial = rem - divisor. If trial is non-negative, rem = trial and quo LSB = 1.
- FIX: apply signs and register the result into the hi/lo shadow; go to DONE.
  - mult: if sign_a^sign_b, negate the full 2*WIDTH-bit product.
  - div: quotient negated if sign_a^sign_b; remainder takes sign_a.
  - Divide by zero: hi=a (original), lo={WIDTH{1'b1}}, div_zero flag set.
  - Overflow case a=0x80000000, b=0xFFFFFFFF (WIDTH=32): lo=0x80000000, hi=0, no flag.
- DONE:
  - hi/lo outputs update on the edge entering DONE; done=1 for exactly this cycle; div_zero valid this cycle only.
  - Next state is IDLE.
  - A start arriving during DONE is ignored; the requester holds start until stall falls.
- Latency:
  - Normal op: done asserted WIDTH+2 cycles after the start-sampling edge (34 for WIDTH=32).
  - Divide by zero: 2 cycles.
- Throughput: a new start is accepted the cycle after done.
- start while busy: ignored; no effect on the current operation.
- flush:
  - In CALC or FIX: next state IDLE; hi/lo unchanged; no done.
  - In DONE: has no effect; the result is already committed.
  - In IDLE: suppresses acceptance of a simultaneous start.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- hi/lo change only on the edge entering DONE (or on reset).

Decomposition:
- Shared package mips_pkg:
  - ALU control code constants: ALU_ADD=4'b0010, ALU_SUB=4'b0110, ALU_AND=4'b0000, ALU_OR=4'b0001, ALU_SLT=4'b0111, ALU_MULT=4'b0011, ALU_DIV=4'b0100.
  - muldiv state encoding constants: IDLE=2'd0, CALC=2'd1, FIX=2'd2, DONE=2'd3.
- One sub-module, muldiv_step: combinational single-iteration datapath (mult add/shift or div trial-subtract/shift) selected by op. The FSM, counter and sign handling stay in muldiv_sequencer.

Test Plan:
- mult a=7, b=-3 (0xFFFFFFFD) -> done at cycle 34; hi=0xFFFFFFFF, lo=0xFFFFFFEB; stall high cycles 0..33.
- mult a=0xFFFFFFFF (-1), b=0xFFFFFFFF -> hi=0, lo=1.
- div a=-17 (0xFFFFFFEF), b=5 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFE (-2).
- div a=100, b=0 -> done at cycle 2, div_zero=1, hi=100, lo=0xFFFFFFFF.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- Mixed controls:
  - start with control=4'b0010 -> stall=0, stays IDLE.
  - flush at cycle 10 of a mult -> IDLE next cycle, hi/lo keep prior values, no done.
  - rst pulsed mid-div -> all outputs 0 asynchronously.
  - start held during busy -> accepted only after done.
